lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address for RV32I load and store instructions.
- Issues a single-outstanding request to data memory over a req/gnt/rvalid handshake. Stores get byte-lane alignment; loads get byte-lane extraction and sign/zero extension.
- Flags misaligned or illegal accesses without touching memory. The core stalls on req_ready low.

Parameters:
- XLEN, 32, datapath and address width (from riscv_pkg). The block supports only 32.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  memory instruction present; address valid
- req_ready  out  1  high only in IDLE
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101)
- req_addr  in  XLEN  effective address (ALU alu_result)
- req_wdata  in  XLEN  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access, valid with rsp_valid
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  word address (req_addr with [1:0] = 00)
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  access complete; mem_rdata valid for loads
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset: all outputs are registered and clear to 0, except req_ready = 1. State goes to IDLE.
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE:
  - On req_valid, capture funct3, is_store, addr[1:0], and the formatted address/wdata/be.
  - Legal and aligned -> REQ with mem_req = 1 from the next cycle.
  - Illegal or misaligned -> ERR.
- Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 00.
- Illegal funct3: loads with 011, 110, 111; stores with funct3[2] = 1 or 011.
- REQ:
  - Hold mem_req, mem_addr, mem_we, mem_be and mem_wdata stable until mem_gnt.
  - On mem_gnt, drop mem_req next cycle and go to WAIT.
- WAIT:
  - On mem_rvalid, pulse rsp_valid for one cycle with rsp_err = 0.
  - Loads: rsp_rdata = extracted data. Stores: rsp_rdata = 0.
  - Then return to IDLE.
  - Memory never asserts mem_rvalid in the same cycle as mem_gnt. The LSU ignores mem_rvalid outside WAIT.
- ERR: lasts one cycle. Pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0, no mem_req, then IDLE.
- Minimum latency for a legal access: accept in cycle 0, mem_req in cycle 1 with gnt, rvalid in cycle 2, rsp_valid in cycle 3.
- Error latency: rsp_valid in cycle 1.
- req_ready = (state == IDLE). Requests while busy are ignored; the core holds them.
- Store formatting (off = addr[1:0]):
  - SB: mem_wdata = 4 copies of wdata[7:0], mem_be = 0001 << off.
  - SH: mem_wdata = 2 copies of wdata[15:0], mem_be = 0011 << off.
  - SW: mem_wdata = wdata, mem_be = 1111.
- Loads: mem_be uses the same rule as stores, and mem_we = 0.
- Load extraction: select byte (8*off) or halfword (16*off[1]).
  - LB/LH sign-extend to XLEN.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rsp_valid has no backpressure.
- Reset mid-operation: go to IDLE immediately. Any later mem_rvalid from the abandoned transaction is ignored and produces no rsp_valid.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, gnt in cycle 1, rvalid in cycle 2 -> mem_addr 0x100, be 1111, rsp_valid in cycle 3, rsp_rdata 0xDEADBEEF, rsp_err 0.
- LB addr 0x103 with mem_rdata 0x80112233 -> be 1000, rsp_rdata 0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> mem_we 1, mem_addr 0x200, be 1100, mem_wdata 0xABCDABCD. rsp_rdata 0 after rvalid.
- LW addr 0x101 -> no mem_req, rsp_valid with rsp_err 1 one cycle after accept. Load funct3 110 -> same response.
- mem_gnt held low for 5 cycles -> mem_req and its fields stay stable, req_ready 0, and a second req_valid is ignored.
- Assert rst in WAIT, then mem_rvalid after reset release -> outputs 0, req_ready 1, no rsp_valid.

Source files
------------

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if - data-memory bus between the load/store unit and data memory.
//
// Signals:
//   mem_req    LSU -> mem   request, held until mem_gnt
//   mem_we     LSU -> mem   write enable (1 = store)
//   mem_addr   LSU -> mem   word-aligned address
//   mem_be     LSU -> mem   byte enables
//   mem_wdata  LSU -> mem   lane-replicated store data
//   mem_gnt    mem -> LSU   request accepted
//   mem_rvalid mem -> LSU   access complete; mem_rdata valid for loads
//   mem_rdata  mem -> LSU   read word
//
// Modports: master = LSU side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - RV32I load/store unit sitting downstream of the ALU.
//
// Takes the ALU result as effective address, issues one outstanding
// req/gnt/rvalid access to data memory, aligns store data onto byte lanes
// and extracts/extends load data. Misaligned or illegal accesses are
// answered with rsp_err without touching memory.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      memory instruction present (address valid)
//   req_ready      high only while idle; the core stalls on low
//   req_is_store   1 = store, 0 = load
//   req_funct3     RV32I funct3
//   req_addr       effective address
//   req_wdata      store data (rs2)
//   rsp_valid      one-cycle completion pulse (no backpressure)
//   rsp_rdata      extended load data; 0 for stores and errors
//   rsp_err        misaligned/illegal access, valid with rsp_valid
//   mem            data-memory bus (lsu_if.master)
//
// XLEN must be 32; the lane logic is written for a 4-byte word.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    lsu_if.master           mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // Registered outputs
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]      mem_be_q,    mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    // Captured request attributes needed at load completion
    logic [2:0]      f3_q,    f3_d;
    logic [1:0]      off_q,   off_d;
    logic            store_q, store_d;

    // ---------------- request decode (incoming, IDLE only) ----------------
    logic [1:0]      req_off;
    logic            req_illegal;
    logic            req_misaligned;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata_fmt;

    assign req_off = req_addr[1:0];

    // Loads: 011, 110, 111 are illegal. Stores: 1xx and 011 are illegal.
    assign req_illegal = req_is_store
                       ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                       : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));

    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0])
                         || ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));

    always_comb begin
        req_be        = 4'b1111;
        req_wdata_fmt = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_fmt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be        = 4'b0011 << req_off;
                req_wdata_fmt = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'b1111;
                req_wdata_fmt = req_wdata;
            end
        endcase
    end

    // ---------------- load extraction (captured attributes) ----------------
    logic [XLEN-1:0] rd_shift;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] load_data;

    assign rd_shift = mem.mem_rdata >> {off_q, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        load_data = mem.mem_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = mem.mem_rdata;
        endcase
    end

    // ---------------- next-state / next-output logic ----------------
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        store_d     = store_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d        = req_funct3;
                    off_d       = req_off;
                    store_d     = req_is_store;
                    mem_we_d    = req_is_store;
                    mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata_fmt;
                    if (req_illegal || req_misaligned) begin
                        // Response is registered here so it is visible during ERR.
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = store_q ? '0 : load_data;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            store_q     <= store_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu - self-checking bench for lsu. Directed cases from the test plan,
// then randomized accesses compared against a behavioural reference model
// that computes the expected bus fields and response from the RV32I rules.
// ---------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    lsu_if #(.XLEN(32)) mem_bus ();

    lsu #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    // Expected behaviour straight from the ISA rules: access size in bytes,
    // legality by funct3 list, alignment by modulo, lanes by arithmetic.
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
        exp_t        e;
        int unsigned size;
        int unsigned off;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] v;
        e    = '0;
        off  = addr % 4;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) begin
            e.err = 1'b1;
        end else if ((addr % size) != 0) begin
            e.err = 1'b1;
        end else begin
            e.addr = addr - off;
            e.be   = 4'(((1 << size) - 1) << off);
            mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            if (size == 1)      e.wdata = (wdata & 32'hFF) * 32'h0101_0101;
            else if (size == 2) e.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            else                e.wdata = wdata;
            if (st) begin
                e.rdata = 32'd0;
            end else begin
                v = (rdata >> (8 * off)) & mask;
                if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // One complete access. gd = cycles mem_gnt stays low, rd = extra cycles
    // before mem_rvalid. poke drives a competing request while stalled.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gd, input int rd, input bit poke,
                          output logic [31:0] got_rdata);
        exp_t e;
        int   n;
        e = model(st, f3, addr, wdata, rdata);
        got_rdata = 32'hXXXX_XXXX;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        if (e.err) begin
            check("err_valid", {31'd0, rsp_valid}, 32'd1);
            check("err_flag", {31'd0, rsp_err}, 32'd1);
            check("err_rdata", rsp_rdata, 32'd0);
            check("err_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
            got_rdata = rsp_rdata;
            @(negedge clk);
            check("err_pulse_end", {31'd0, rsp_valid}, 32'd0);
            check("err_ready", {31'd0, req_ready}, 32'd1);
        end else begin
            check("req_rspv", {31'd0, rsp_valid}, 32'd0);
            check("req_on", {31'd0, mem_bus.mem_req}, 32'd1);
            check("req_addr", mem_bus.mem_addr, e.addr);
            check("req_we", {31'd0, mem_bus.mem_we}, {31'd0, st});
            check("req_be", {28'd0, mem_bus.mem_be}, {28'd0, e.be});
            if (st) check("req_wdata", mem_bus.mem_wdata, e.wdata);
            for (int i = 0; i < gd; i++) begin
                if (poke) begin
                    req_valid    = 1'b1;
                    req_addr     = ~addr;
                    req_is_store = ~st;
                    req_funct3   = 3'd2;
                end
                @(negedge clk);
                check("stall_req", {31'd0, mem_bus.mem_req}, 32'd1);
                check("stall_addr", mem_bus.mem_addr, e.addr);
                check("stall_be", {28'd0, mem_bus.mem_be}, {28'd0, e.be});
                check("stall_we", {31'd0, mem_bus.mem_we}, {31'd0, st});
                if (st) check("stall_wdata", mem_bus.mem_wdata, e.wdata);
                check("stall_ready", {31'd0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            mem_bus.mem_gnt = 1'b1;
            @(negedge clk);
            mem_bus.mem_gnt = 1'b0;
            check("req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
            check("wait_rspv", {31'd0, rsp_valid}, 32'd0);
            for (int i = 0; i < rd; i++) begin
                @(negedge clk);
                check("wait_idle", {31'd0, rsp_valid}, 32'd0);
                check("wait_ready", {31'd0, req_ready}, 32'd0);
            end
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = rdata;
            @(negedge clk);
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = $urandom;
            check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("rsp_err", {31'd0, rsp_err}, 32'd0);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_ready", {31'd0, req_ready}, 32'd1);
            got_rdata = rsp_rdata;
            @(negedge clk);
            check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] got;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mreq", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst_maddr", mem_bus.mem_addr, 32'd0);
        check("rst_mbe", {28'd0, mem_bus.mem_be}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test-plan accesses
        run_op(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0, got);
        check("tp_lw", got, 32'hDEAD_BEEF);
        run_op(1'b0, 3'b000, 32'h103, 32'd0, 32'h8011_2233, 0, 0, 1'b0, got);
        check("tp_lb", got, 32'hFFFF_FF80);
        run_op(1'b0, 3'b100, 32'h103, 32'd0, 32'h8011_2233, 1, 1, 1'b0, got);
        check("tp_lbu", got, 32'h0000_0080);
        run_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 1'b0, got);
        check("tp_sh_rdata", got, 32'd0);
        run_op(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0, 1'b0, got);
        run_op(1'b0, 3'b110, 32'h100, 32'd0, 32'd0, 0, 0, 1'b0, got);
        run_op(1'b1, 3'b100, 32'h100, 32'h1, 32'd0, 0, 0, 1'b0, got);
        run_op(1'b0, 3'b101, 32'h302, 32'd0, 32'h8765_4321, 0, 0, 1'b0, got);
        check("tp_lhu_hi", got, 32'h0000_8765);
        run_op(1'b0, 3'b010, 32'h400, 32'd0, 32'h0BAD_F00D, 5, 0, 1'b1, got);
        check("tp_stall_lw", got, 32'h0BAD_F00D);

        // Reset while waiting for rvalid; the late rvalid must be ignored
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_mreq", {31'd0, mem_bus.mem_req}, 32'd0);
        check("mid_rst_maddr", mem_bus.mem_addr, 32'd0);
        check("mid_rst_rspv", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        check("stale_rspv", {31'd0, rsp_valid}, 32'd0);
        check("stale_ready", {31'd0, req_ready}, 32'd1);
        check("stale_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        check("stale_rspv2", {31'd0, rsp_valid}, 32'd0);

        // Randomized accesses against the reference model
        for (int k = 0; k < 300; k++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
